ped_request_sequencer: RTL and testbench
========================================

PED_REQUEST_SEQUENCER -- requirements
Module: ped_request_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clock cycles per one-second tick.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, stable cycles required to accept a button level.
REQ-003 Parameter MIN_GREEN_S, default 5, minimum seconds in a green phase (0 or 3) before a pedestrian request may end it.
REQ-004 Parameter MAX_GREEN_S, default 20, seconds after which a green phase ends unconditionally.
REQ-005 Parameter FLASH_S, default 15, seconds in a flashing-walk phase (1 or 4).
REQ-006 Parameter YELLOW_S, default 3, seconds in a yellow phase (2 or 5).
REQ-007 clock input 1, single system clock; all logic on its rising edge.
REQ-008 resetn input 1, reset; asynchronous and active-low.
REQ-009 ped_btn1 input 1, raw asynchronous push-button, active-high, crossing-1 request.
REQ-010 ped_btn2 input 1, raw asynchronous push-button, active-high, crossing-2 request.
REQ-011 phase input 4, current state code 0..5 from the light control FSM.
REQ-012 change output 1, level request to advance the control FSM one state.
REQ-013 req1_pending output 1, latched crossing-1 request indicator.
REQ-014 req2_pending output 1, latched crossing-2 request indicator.
REQ-015 elapsed_s output 8, whole seconds spent in the current phase, saturating at 255.
REQ-016 phase_err output 1, high while phase is outside 0..5.

Function
REQ-017 Each button: 2-flop synchronizer, then debounce; a debounced rising edge is the press event.
REQ-018 Prescaler counts 0..CLK_HZ-1; sec_tick is a one-cycle pulse at wrap.
REQ-019 Cycle after a sampled phase differs from the registered phase: elapsed_s=0, prescaler=0, change=0.
REQ-020 Otherwise elapsed_s increments on sec_tick, saturating at 255.
REQ-021 Phases 1/4: change asserts when elapsed_s>=FLASH_S; phases 2/5: when elapsed_s>=YELLOW_S.
REQ-022 Phase 0: change asserts when (elapsed_s>=MIN_GREEN_S and req1_pending) or elapsed_s>=MAX_GREEN_S; phase 3 the same using req2_pending.
REQ-023 change is registered (one cycle after its condition holds) and stays high until the phase-change acknowledge of REQ-019; no retraction otherwise.
REQ-024 A press sets reqN_pending unless that crossing is currently walking (crossing 1 in phase 3/4, crossing 2 in phase 0/1); such presses are ignored.
REQ-025 req1_pending clears on entry to phase 3, req2_pending on entry to phase 0; on the same cycle, clear wins over press.
REQ-026 A press arriving after MIN_GREEN_S has already elapsed in the matching green phase raises change in the cycle after reqN_pending sets.
REQ-027 Invalid phase: change=0, elapsed_s held at 0, phase_err=1; normal operation resumes via REQ-019 when a valid code returns.
REQ-028 A phase change without a preceding change request (external FSM reset) is handled identically to an acknowledge.

Reset
REQ-029 resetn low: change=0, req1_pending=0, req2_pending=0, elapsed_s=0, phase_err=0, prescaler=0, synchronizers/debouncers 0, registered phase=0.
REQ-030 Reset asserted mid-phase aborts any pending change immediately; all requests are lost.

Structure
REQ-031 Shared package holds phase codes (PH_T1R_T2G=0 .. PH_T1Y_T2R=5) and the default timing constants.
REQ-032 One sub-module btn_debounce (synchronizer + debounce counter, press-pulse output), instantiated twice.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4, MIN 5, MAX 20, FLASH 15, YELLOW 3)
REQ-033 Phase 0, no presses -> change rises at cycle 201 (20 s), falls 1 cycle after phase->1.
REQ-034 Phase 0, clean btn1 press at 1 s -> req1_pending=1 after sync+debounce; change rises after 5 s; req1_pending clears when phase->3.
REQ-035 btn1 bounce shorter than 4 cycles -> no pending set; btn2 pressed in phase 1 -> ignored, req2_pending stays 0.
REQ-036 Phase 2 -> change at 3 s; phase 4 -> change at 15 s; phase held with change high -> change stays high.
REQ-037 phase=7 -> phase_err=1, change=0; resetn pulsed low mid-phase 0 with pending request -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ped_request_sequencer_pkg.sv
// Shared phase codes and default timing for the pedestrian request sequencer.
// Phase codes match the external light control FSM state encoding.
package ped_request_sequencer_pkg;

  typedef enum logic [3:0] {
    PH_T1R_T2G = 4'd0,
    PH_T1R_T2W = 4'd1,
    PH_T1R_T2Y = 4'd2,
    PH_T1G_T2R = 4'd3,
    PH_T1W_T2R = 4'd4,
    PH_T1Y_T2R = 4'd5
  } phase_t;

  localparam int DEF_CLK_HZ          = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_MIN_GREEN_S     = 5;
  localparam int DEF_MAX_GREEN_S     = 20;
  localparam int DEF_FLASH_S         = 15;
  localparam int DEF_YELLOW_S        = 3;

  function automatic logic phase_valid(input logic [3:0] code);
    return code <= 4'(PH_T1Y_T2R);
  endfunction

endpackage

// File: rtl/ped_request_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, down-counter debounce,
// one-cycle press pulse on each accepted rising level.
module btn_debounce
  import ped_request_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic resetn,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The new level is accepted once it has differed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level <= sync2;
        cnt   <= RELOAD;
        press <= sync2;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ped_request_sequencer.sv
// Pedestrian request sequencer: times the current light phase in seconds and
// raises a registered change request toward the external light control FSM.
module ped_request_sequencer
  import ped_request_sequencer_pkg::*;
#(
  parameter int CLK_HZ          = DEF_CLK_HZ,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_GREEN_S     = DEF_MIN_GREEN_S,
  parameter int MAX_GREEN_S     = DEF_MAX_GREEN_S,
  parameter int FLASH_S         = DEF_FLASH_S,
  parameter int YELLOW_S        = DEF_YELLOW_S
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ped_btn1,
  input  logic       ped_btn2,
  input  logic [3:0] phase,
  output logic       change,
  output logic       req1_pending,
  output logic       req2_pending,
  output logic [7:0] elapsed_s,
  output logic       phase_err
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_TOP  = PW'(CLK_HZ - 1);
  localparam logic [7:0]    MIN_L    = 8'(MIN_GREEN_S);
  localparam logic [7:0]    MAX_L    = 8'(MAX_GREEN_S);
  localparam logic [7:0]    FLASH_L  = 8'(FLASH_S);
  localparam logic [7:0]    YELLOW_L = 8'(YELLOW_S);

  logic [PW-1:0] prescaler;
  logic [3:0]    phase_q;
  logic          sec_tick;
  logic          phase_ok;
  logic          phase_new;
  logic          press1;
  logic          press2;
  logic          walk1;
  logic          walk2;
  logic          change_cond;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
    .clock  (clock),
    .resetn (resetn),
    .btn    (ped_btn1),
    .press  (press1)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn2 (
    .clock  (clock),
    .resetn (resetn),
    .btn    (ped_btn2),
    .press  (press2)
  );

  assign sec_tick  = (prescaler == PRE_TOP);
  assign phase_ok  = phase_valid(phase);
  assign phase_new = (phase != phase_q);
  assign walk1     = (phase_q == PH_T1G_T2R) || (phase_q == PH_T1W_T2R);
  assign walk2     = (phase_q == PH_T1R_T2G) || (phase_q == PH_T1R_T2W);

  always_comb begin
    change_cond = 1'b0;
    case (phase_q)
      PH_T1R_T2G: change_cond = (elapsed_s >= MAX_L) || (req1_pending && (elapsed_s >= MIN_L));
      PH_T1G_T2R: change_cond = (elapsed_s >= MAX_L) || (req2_pending && (elapsed_s >= MIN_L));
      PH_T1R_T2W, PH_T1W_T2R: change_cond = (elapsed_s >= FLASH_L);
      PH_T1R_T2Y, PH_T1Y_T2R: change_cond = (elapsed_s >= YELLOW_L);
      default:    change_cond = 1'b0;
    endcase
  end

  // Any phase movement, requested or not, acts as the acknowledge; invalid codes park the timer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_q   <= '0;
      phase_err <= 1'b0;
      prescaler <= '0;
      elapsed_s <= '0;
      change    <= 1'b0;
    end else begin
      phase_q   <= phase;
      phase_err <= !phase_ok;
      if (!phase_ok || phase_new) begin
        prescaler <= '0;
        elapsed_s <= '0;
        change    <= 1'b0;
      end else begin
        prescaler <= sec_tick ? '0 : prescaler + PW'(1);
        if (sec_tick && (elapsed_s != 8'hFF))
          elapsed_s <= elapsed_s + 8'd1;
        if (change_cond)
          change <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      req1_pending <= 1'b0;
      req2_pending <= 1'b0;
    end else begin
      if (phase_new && (phase == PH_T1G_T2R))
        req1_pending <= 1'b0;
      else if (press1 && !walk1)
        req1_pending <= 1'b1;

      if (phase_new && (phase == PH_T1R_T2G))
        req2_pending <= 1'b0;
      else if (press2 && !walk2)
        req2_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ped_request_sequencer.sv
// Directed bench for ped_request_sequencer with a 10-cycle second and 4-cycle debounce.
module tb_ped_request_sequencer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ped_btn1 = 1'b0;
  logic       ped_btn2 = 1'b0;
  logic [3:0] phase = 4'd0;
  logic       change;
  logic       req1_pending;
  logic       req2_pending;
  logic [7:0] elapsed_s;
  logic       phase_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  ped_request_sequencer #(
    .CLK_HZ          (10),
    .DEBOUNCE_CYCLES (4),
    .MIN_GREEN_S     (5),
    .MAX_GREEN_S     (20),
    .FLASH_S         (15),
    .YELLOW_S        (3)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .ped_btn1     (ped_btn1),
    .ped_btn2     (ped_btn2),
    .phase        (phase),
    .change       (change),
    .req1_pending (req1_pending),
    .req2_pending (req2_pending),
    .elapsed_s    (elapsed_s),
    .phase_err    (phase_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives a new phase code; the following edge is the acknowledge edge.
  task automatic set_phase(input logic [3:0] p);
    phase = p;
    tick();
  endtask

  // change must still be low n-1 edges after the acknowledge and high on edge n.
  task automatic expect_change_at(input string tag, input int n);
    ticks(n - 1);
    check_val({tag, " early"}, change, 0);
    tick();
    check_val({tag, " rise"}, change, 1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_val("rst change", change, 0);
    check_val("rst req1", req1_pending, 0);
    check_val("rst req2", req2_pending, 0);
    check_val("rst elapsed", elapsed_s, 0);
    check_val("rst phase_err", phase_err, 0);
    resetn = 1'b1;

    // Phase 0 with no requests runs to the 20 s maximum.
    ticks(200);
    check_val("ph0 max early", change, 0);
    check_val("ph0 elapsed 20", elapsed_s, 20);
    tick();
    check_val("ph0 max rise", change, 1);
    ticks(5);
    check_val("ph0 change held", change, 1);

    set_phase(4'd1);
    check_val("ph1 ack change", change, 0);
    check_val("ph1 ack elapsed", elapsed_s, 0);

    ped_btn2 = 1'b1;
    ticks(8);
    ped_btn2 = 1'b0;
    ticks(10);
    check_val("btn2 walking ignored", req2_pending, 0);

    ped_btn1 = 1'b1;
    ticks(3);
    ped_btn1 = 1'b0;
    ticks(10);
    check_val("btn1 bounce rejected", req1_pending, 0);

    set_phase(4'd2);
    expect_change_at("ph2 yellow", 31);

    // Direct jump back to phase 0 without a request path.
    set_phase(4'd0);
    check_val("ph0 reentry change", change, 0);
    ticks(10);
    ped_btn1 = 1'b1;
    ticks(6);
    check_val("btn1 pending early", req1_pending, 0);
    tick();
    check_val("btn1 pending set", req1_pending, 1);
    ped_btn1 = 1'b0;
    ticks(33);
    check_val("ph0 min early", change, 0);
    tick();
    check_val("ph0 min rise", change, 1);

    set_phase(4'd3);
    check_val("ph3 req1 cleared", req1_pending, 0);
    check_val("ph3 ack change", change, 0);
    ticks(60);
    ped_btn2 = 1'b1;
    ticks(6);
    check_val("btn2 late early", req2_pending, 0);
    tick();
    check_val("btn2 late set", req2_pending, 1);
    check_val("ph3 late change early", change, 0);
    tick();
    check_val("ph3 late change rise", change, 1);
    ped_btn2 = 1'b0;

    set_phase(4'd4);
    expect_change_at("ph4 flash", 151);
    check_val("req2 kept in ph4", req2_pending, 1);

    set_phase(4'd5);
    expect_change_at("ph5 yellow", 31);

    set_phase(4'd0);
    check_val("ph0 req2 cleared", req2_pending, 0);
    ticks(25);
    check_val("ph0 elapsed 2", elapsed_s, 2);

    set_phase(4'd7);
    check_val("bad phase_err", phase_err, 1);
    check_val("bad change", change, 0);
    check_val("bad elapsed", elapsed_s, 0);
    ticks(15);
    check_val("bad elapsed held", elapsed_s, 0);
    check_val("bad change held", change, 0);

    set_phase(4'd0);
    check_val("recover phase_err", phase_err, 0);
    ped_btn1 = 1'b1;
    ticks(8);
    ped_btn1 = 1'b0;
    ticks(52);
    check_val("pre-reset req1", req1_pending, 1);
    check_val("pre-reset change", change, 1);
    check_val("pre-reset elapsed", elapsed_s, 6);

    #2;
    resetn = 1'b0;
    #1;
    check_val("async rst change", change, 0);
    check_val("async rst req1", req1_pending, 0);
    check_val("async rst req2", req2_pending, 0);
    check_val("async rst elapsed", elapsed_s, 0);
    check_val("async rst phase_err", phase_err, 0);
    #10;
    resetn = 1'b1;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
